// File: rtl/pcm_law_pkg.sv
// pcm_law_pkg
// Shared constants for the G.711 compressor: FSM state codes, mu-law
// bias/clip limits and the output inversion masks for both laws.
package pcm_law_pkg;

    // FSM state encoding
    typedef logic [1:0] pcm_state_t;
    localparam pcm_state_t ST_IDLE   = 2'd0;
    localparam pcm_state_t ST_PREP   = 2'd1;
    localparam pcm_state_t ST_SEARCH = 2'd2;
    localparam pcm_state_t ST_DONE   = 2'd3;

    // Number of segment-search cycles (one candidate bit per cycle)
    localparam int unsigned SEARCH_CYCLES = 8;

    // mu-law magnitude bias and clip level (13-bit domain)
    localparam logic [12:0] MU_BIAS = 13'd33;
    localparam logic [12:0] MU_CLIP = 13'd8158;

    // Output inversion masks
    localparam logic [7:0] MU_MASK_POS = 8'hFF;
    localparam logic [7:0] MU_MASK_NEG = 8'h7F;
    localparam logic [7:0] A_MASK_POS  = 8'hD5;
    localparam logic [7:0] A_MASK_NEG  = 8'h55;

endpackage

// File: rtl/pcm_mag_prep.sv
// pcm_mag_prep
// Combinational front end of the compressor. Splits a 14-bit two's
// complement sample into sign and a 13-bit search value.
//   sin  : captured linear sample
//   law  : 1 = A-law, 0 = mu-law
//   sign : sample sign (1 = negative)
//   val  : mu-law -> clipped magnitude + bias (b)
//          A-law  -> 12-bit magnitude shifted left by one, so both laws
//                    search the same bit positions [12:5] of val
module pcm_mag_prep
    import pcm_law_pkg::*;
(
    input  logic [13:0] sin,
    input  logic        law,
    output logic        sign,
    output logic [12:0] val
);

    logic [13:0] abs_mu;
    logic [12:0] clip_mu;
    logic [11:0] mag_a;

    always_comb begin
        sign   = sin[13];
        // -8192 maps to 14'h2000, which is still the correct unsigned magnitude
        abs_mu = sin[13] ? (~sin + 14'd1) : sin;
        clip_mu = (abs_mu > {1'b0, MU_CLIP}) ? MU_CLIP : abs_mu[12:0];
        // A-law works on SIN >>> 1; for negatives -v-1 is simply ~v
        mag_a  = sin[13] ? ~sin[12:1] : sin[12:1];
        if (law) begin
            val = {mag_a, 1'b0};
        end else begin
            val = clip_mu + MU_BIAS;
        end
    end

endmodule

// File: rtl/pcm_compress.sv
// pcm_compress
// Sequential 14-bit linear to 8-bit G.711 (A-law / mu-law) compressor.
// One sample at a time: accept, prepare, 8-cycle MSB-first segment search,
// then present the code word until the downstream takes it.
//   clk        : clock, all state on rising edge
//   reset      : asynchronous active-low reset
//   SIN        : 14-bit two's complement sample
//   LAW        : 1 = A-law, 0 = mu-law (captured with SIN)
//   SIN_VALID  : SIN/LAW valid
//   SIN_READY  : block idle and able to accept
//   SOUT       : 8-bit G.711 code word
//   SOUT_VALID : SOUT holds a result
//   SOUT_READY : downstream accepts SOUT
module pcm_compress
    import pcm_law_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic [13:0] SIN,
    input  logic        LAW,
    input  logic        SIN_VALID,
    output logic        SIN_READY,
    output logic [7:0]  SOUT,
    output logic        SOUT_VALID,
    input  logic        SOUT_READY
);

    pcm_state_t  state_reg;
    logic [13:0] sin_reg;
    logic        law_reg;
    logic        sign_reg;
    logic [12:0] val_reg;
    logic [2:0]  cnt_reg;
    logic        found_reg;
    logic [2:0]  seg_reg;
    logic [7:0]  sout_reg;
    logic        sout_valid_reg;

    logic        prep_sign;
    logic [12:0] prep_val;
    logic [3:0]  bit_idx;
    logic        test_bit;
    logic [3:0]  mant_shift;
    logic [3:0]  mant;
    logic [7:0]  mask;
    logic [7:0]  code;

    pcm_mag_prep u_prep (
        .sin  (sin_reg),
        .law  (law_reg),
        .sign (prep_sign),
        .val  (prep_val)
    );

    // Search cycle k tests val[12-k]; a hit there means segment 7-k for
    // both laws thanks to the A-law pre-shift in pcm_mag_prep.
    assign bit_idx  = 4'd12 - {1'b0, cnt_reg};
    assign test_bit = val_reg[bit_idx];

    // Mantissa shift expressed on val: mu-law b >> (seg+1); A-law
    // mag >> seg == val >> (seg+1), with segments 0/1 both using mag >> 1.
    always_comb begin
        if (law_reg && (seg_reg < 3'd2)) begin
            mant_shift = 4'd2;
        end else begin
            mant_shift = {1'b0, seg_reg} + 4'd1;
        end
        mant = 4'(val_reg >> mant_shift);
        if (law_reg) begin
            mask = sign_reg ? A_MASK_NEG : A_MASK_POS;
        end else begin
            mask = sign_reg ? MU_MASK_NEG : MU_MASK_POS;
        end
        code = {1'b0, seg_reg, mant} ^ mask;
    end

    // Ready only while idle and out of reset (reset gates it immediately)
    assign SIN_READY  = (state_reg == ST_IDLE) && reset;
    assign SOUT       = sout_reg;
    assign SOUT_VALID = sout_valid_reg;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg      <= ST_IDLE;
            sin_reg        <= '0;
            law_reg        <= 1'b0;
            sign_reg       <= 1'b0;
            val_reg        <= '0;
            cnt_reg        <= '0;
            found_reg      <= 1'b0;
            seg_reg        <= '0;
            sout_reg       <= '0;
            sout_valid_reg <= 1'b0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (SIN_VALID && SIN_READY) begin
                        sin_reg   <= SIN;
                        law_reg   <= LAW;
                        state_reg <= ST_PREP;
                    end
                end
                ST_PREP: begin
                    sign_reg  <= prep_sign;
                    val_reg   <= prep_val;
                    cnt_reg   <= '0;
                    found_reg <= 1'b0;
                    seg_reg   <= '0;
                    state_reg <= ST_SEARCH;
                end
                ST_SEARCH: begin
                    // Sticky: only the first (highest) set bit defines seg
                    if (!found_reg && test_bit) begin
                        found_reg <= 1'b1;
                        seg_reg   <= 3'd7 - cnt_reg;
                    end
                    cnt_reg <= cnt_reg + 3'd1;
                    if (cnt_reg == 3'(SEARCH_CYCLES - 1)) begin
                        state_reg <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    // First DONE cycle loads the result; afterwards hold
                    // until the downstream handshake.
                    if (!sout_valid_reg) begin
                        sout_reg       <= code;
                        sout_valid_reg <= 1'b1;
                    end else if (SOUT_READY) begin
                        sout_valid_reg <= 1'b0;
                        state_reg      <= ST_IDLE;
                    end
                end
                default: begin
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/pcm_compress.md
PCM_COMPRESS -- requirements
Module: pcm_compress

Interface
REQ-001 clk  input  1  single clock; all state updates on rising edge.
REQ-002 reset  input  1  asynchronous, active-low reset.
REQ-003 SIN  input  14  linear sample, two's complement.
REQ-004 LAW  input  1  law select: 1 = A-law, 0 = mu-law; sampled with SIN.
REQ-005 SIN_VALID  input  1  SIN/LAW valid.
REQ-006 SIN_READY  output  1  block can accept a sample.
REQ-007 SOUT  output  8  G.711 PCM code word.
REQ-008 SOUT_VALID  output  1  SOUT holds a result.
REQ-009 SOUT_READY  input  1  downstream accepts SOUT.

Function
REQ-010 The block SHALL be the inverse of the team's EXPAND block: 14-bit linear in, 8-bit A-/mu-law out.
REQ-011 The FSM SHALL have states IDLE -> PREP -> SEARCH (8 cycles) -> DONE -> IDLE.
REQ-012 SIN_READY SHALL be 1 only in IDLE with reset deasserted.
REQ-013 Acceptance SHALL occur on the edge where SIN_VALID & SIN_READY; SIN and LAW SHALL be captured there, and later input changes SHALL be ignored until the next acceptance.
REQ-014 PREP, mu-law: sign = SIN[13]; m = |SIN|, clipped to 8158; b = m + 33 (13 bits).
REQ-015 PREP, A-law: v = SIN >>> 1 (13-bit); sign = v[12]; magnitude = v if positive, else -v-1 (12 bits).
REQ-016 SEARCH SHALL test one bit per cycle, MSB first, for a fixed 8 cycles with a sticky found flag.
- mu-law tests b[12..5]; seg = p-5.
- A-law tests magnitude[11..4]; seg = p-4.
- p = highest set bit index; no bit found -> seg = 0.
REQ-017 Mantissa: mu-law (b >> (seg+1)) & 0xF; A-law (mag >> 1) & 0xF if seg < 2, else (mag >> seg) & 0xF.
REQ-018 Code word: mu-law {seg,mant} XOR 0xFF (positive) or 0x7F (negative); A-law {0,seg,mant} XOR 0xD5 (positive) or 0x55 (negative).
REQ-019 SOUT_VALID SHALL rise exactly 10 rising edges after the acceptance edge (1 PREP + 8 SEARCH + 1 DONE load).
REQ-020 While SOUT_VALID & !SOUT_READY, SOUT SHALL hold stable.
REQ-021 On the edge where SOUT_VALID & SOUT_READY, the FSM SHALL go to IDLE and SOUT_VALID SHALL drop.
- No accept is possible in that same cycle.
- Minimum sample period is 12 cycles.
REQ-022 SOUT_READY held high in DONE SHALL complete the handshake in one cycle; SOUT_READY outside DONE SHALL be ignored.
REQ-023 SIN_VALID while SIN_READY = 0 SHALL be ignored; no sample SHALL be queued.

Reset
REQ-024 reset low SHALL immediately force:
- state = IDLE
- SOUT = 8'h00, SOUT_VALID = 0, SIN_READY = 0
- all internal registers cleared.
REQ-025 reset asserted in any state SHALL abort the in-flight sample with no output produced.
REQ-026 SIN_READY SHALL be 1 in the first cycle after reset deasserts.

Structure
REQ-027 Package pcm_law_pkg SHALL hold the state enum and constants: MU_BIAS = 33, MU_CLIP = 8158, MU_MASK_POS = 0xFF, MU_MASK_NEG = 0x7F, A_MASK_POS = 0xD5, A_MASK_NEG = 0x55.
REQ-028 Sub-module pcm_mag_prep (combinational sign/magnitude/bias/clip) SHALL be instantiated once; the FSM, search and code assembly SHALL stay in pcm_compress.

Verification
REQ-029 mu-law codes: SIN 14'h0000 -> 0xFF; 14'h3FFF (-1) -> 0x7E; 14'h1FFF -> 0x80 (clip); 14'h2000 (-8192) -> 0x00.
REQ-030 A-law codes: SIN 14'h0000 -> 0xD5; 14'h3FFE (-2) -> 0x55; 14'h0040 -> 0xC5 (segment 1 boundary); 14'h1FFE -> 0xAA.
REQ-031 Latency and backpressure:
- accept at edge N -> SOUT_VALID = 1 from edge N+10.
- hold SOUT_READY = 0 for 5 cycles -> SOUT stable, SIN_READY = 0.
- release -> SIN_READY = 1 one cycle later.
REQ-032 Change SIN and LAW during SEARCH -> result matches the values captured at acceptance; SIN_VALID pulses while busy are ignored.
REQ-033 Assert reset during SEARCH -> SOUT_VALID = 0 and SOUT = 0x00 immediately; after release, the next sample produces the correct code.
REQ-034 Random run: 10000 random SIN/LAW samples with random SOUT_READY -> every SOUT equals the software G.711 model, and expanding SOUT with EXPAND returns the quantized SIN.
